// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the key debouncer.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_FILT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_FILT = 2'd3
  } state_e;

  localparam logic [7:0] GLITCH_SAT = 8'd255;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a parameterised reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/key_debounce.sv
// Debounces a raw key input into a clean active-high level, counting rejected
// transitions in a saturating diagnostic counter.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  input  logic       glitch_clr,
  output logic       key_level,
  output logic       filtering,
  output logic [7:0] glitch_cnt
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_sync;
  logic             w_key_act;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_key_level;
  logic             w_level_nxt;
  logic             r_filtering;
  logic             w_filt_nxt;
  logic             w_glitch_evt;
  logic [7:0]       r_glitch_cnt;
  logic [7:0]       w_glitch_nxt;

  // Sync flops idle at the un-pressed raw level so reset never looks like a press.
  sync_2ff #(
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (key_in),
    .o_q   (w_sync)
  );

  assign w_key_act = ACTIVE_LOW ? ~w_sync : w_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RELEASED;
      r_cnt        <= '0;
      r_key_level  <= 1'b0;
      r_filtering  <= 1'b0;
      r_glitch_cnt <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_key_level  <= w_level_nxt;
      r_filtering  <= w_filt_nxt;
      r_glitch_cnt <= w_glitch_nxt;
    end
  end

  // Filter FSM: a new level needs the entry sample plus DEBOUNCE_CYCLES counting samples.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_level_nxt  = r_key_level;
    w_glitch_evt = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_key_act) begin
          w_state_nxt = PRESS_FILT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_FILT: begin
        if (!w_key_act) begin
          w_state_nxt  = RELEASED;
          w_cnt_nxt    = '0;
          w_glitch_evt = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_level_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!w_key_act) begin
          w_state_nxt = RELEASE_FILT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_FILT: begin
        if (w_key_act) begin
          w_state_nxt  = PRESSED;
          w_cnt_nxt    = '0;
          w_glitch_evt = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = RELEASED;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
        w_level_nxt = 1'b0;
      end
    endcase

    w_filt_nxt = (w_state_nxt == PRESS_FILT) || (w_state_nxt == RELEASE_FILT);

    // Clear takes priority over a coincident glitch event.
    w_glitch_nxt = r_glitch_cnt;
    if (glitch_clr) begin
      w_glitch_nxt = 8'd0;
    end else if (w_glitch_evt && (r_glitch_cnt != GLITCH_SAT)) begin
      w_glitch_nxt = r_glitch_cnt + 8'd1;
    end
  end

  assign key_level  = r_key_level;
  assign filtering  = r_filtering;
  assign glitch_cnt = r_glitch_cnt;

endmodule
